// File: rtl/entrada_pkg.sv
// Shared key codes, state encoding and key classification for the code-entry controller.
package entrada_pkg;

    localparam logic [3:0] KEY_BACKSPACE = 4'hA;
    localparam logic [3:0] KEY_CLEAR     = 4'hE;
    localparam logic [3:0] KEY_ENTER     = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        DONE
    } entrada_state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'h9;
    endfunction

endpackage

// File: rtl/detector_de_borda.sv
// Rising-edge detector for the keypad valid strobe; one event per press, no repeat while held.
module detector_de_borda (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev_q;
    logic armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= level;
            armed_q <= 1'b1;
        end
    end

    // A level already high when reset releases must not count as a press.
    assign rise = level & ~prev_q & armed_q;

endmodule

// File: rtl/entrada_de_codigo.sv
// Key-entry controller: assembles BCD digits, handles backspace/clear/enter, hands off on valid/ready.
// Optional inactivity timeout in ENTRY is built when ENTRADA_TIMEOUT_EN is defined.
module entrada_de_codigo #(
    parameter int unsigned MAX_DIGITS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              tecla_value,
    input  logic                    tecla_valid,
    output logic [4*MAX_DIGITS-1:0] code_data,
    output logic [3:0]              code_len,
    output logic                    code_valid,
    input  logic                    code_ready,
    output logic                    entry_active,
    output logic                    overflow,
    output logic                    timeout
);

    import entrada_pkg::*;

    localparam int unsigned W       = 4 * MAX_DIGITS;
    localparam logic [3:0]  MAX_LEN = 4'(MAX_DIGITS);

    if (MAX_DIGITS < 1 || MAX_DIGITS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("entrada_de_codigo: MAX_DIGITS must be 1..8 and TIMEOUT_CYCLES >= 2");
    end

    entrada_state_t state_q, state_d;
    logic [W-1:0]   buf_q, buf_d;
    logic [3:0]     len_q, len_d;
    logic           ovf_q, ovf_d;
    logic           key_event;
    logic           expired;

    detector_de_borda u_borda (
        .clk   (clk),
        .rst   (rst),
        .level (tecla_valid),
        .rise  (key_event)
    );

`ifdef ENTRADA_TIMEOUT_EN
    localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;

    assign expired = (state_q == ENTRY) && (cnt_q == CNT_LAST);

    // Any key activity or state change restarts the inactivity window.
    always_comb begin
        cnt_d = '0;
        if (state_q == ENTRY && !key_event && state_d == state_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout = to_q;
`else
    assign expired = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        len_d   = len_q;
        ovf_d   = 1'b0;
`ifdef ENTRADA_TIMEOUT_EN
        to_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (key_event && is_digit(tecla_value)) begin
                    buf_d   = W'(tecla_value);
                    len_d   = 4'd1;
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (key_event) begin
                    if (is_digit(tecla_value)) begin
                        if (len_q < MAX_LEN) begin
                            buf_d = (buf_q << 4) | W'(tecla_value);
                            len_d = len_q + 4'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (tecla_value == KEY_BACKSPACE) begin
                        buf_d = buf_q >> 4;
                        len_d = len_q - 4'd1;
                        if (len_q == 4'd1) begin
                            state_d = IDLE;
                        end
                    end else if (tecla_value == KEY_CLEAR) begin
                        buf_d   = '0;
                        len_d   = 4'd0;
                        state_d = IDLE;
                    end else if (tecla_value == KEY_ENTER) begin
                        state_d = DONE;
                    end
                end else if (expired) begin
                    buf_d   = '0;
                    len_d   = 4'd0;
                    state_d = IDLE;
`ifdef ENTRADA_TIMEOUT_EN
                    to_d    = 1'b1;
`endif
                end
            end
            DONE: begin
                // Keys are dropped here, even in the handshake cycle.
                if (code_ready) begin
                    buf_d   = '0;
                    len_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                buf_d   = '0;
                len_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            len_q   <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    assign code_data    = buf_q;
    assign code_len     = len_q;
    assign code_valid   = (state_q == DONE);
    assign entry_active = (state_q == ENTRY);
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_entrada_de_codigo.sv
// Directed bench for entrada_de_codigo with a scoreboard checking every completed code handoff.
module tb_entrada_de_codigo;

    localparam int unsigned MAX_DIGITS     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 50;

    logic        clk;
    logic        rst;
    logic [3:0]  tecla_value;
    logic        tecla_valid;
    logic [15:0] code_data;
    logic [3:0]  code_len;
    logic        code_valid;
    logic        code_ready;
    logic        entry_active;
    logic        overflow;
    logic        timeout;

    entrada_de_codigo #(
        .MAX_DIGITS     (MAX_DIGITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tecla_value  (tecla_value),
        .tecla_valid  (tecla_valid),
        .code_data    (code_data),
        .code_len     (code_len),
        .code_valid   (code_valid),
        .code_ready   (code_ready),
        .entry_active (entry_active),
        .overflow     (overflow),
        .timeout      (timeout)
    );

    typedef struct {
        logic [15:0] data;
        logic [3:0]  len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ovf_cnt = 0;
    int   to_cnt = 0;
    int   to_cyc = 0;
    int   ev_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clean press: the event is sampled at the first edge, then the key is released.
    task automatic press(input logic [3:0] v);
        tecla_value = v;
        tecla_valid = 1'b1;
        tick();
        ev_cyc = cyc;
        tecla_valid = 1'b0;
        tick();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: pulse counting and scoreboard comparison on each handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (overflow) ovf_cnt++;
            if (timeout) begin
                to_cnt++;
                to_cyc = cyc;
            end
            if (code_valid && code_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got code %0h len %0d expected no handoff",
                             code_data, code_len);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", 32'(code_data), 32'(e.data));
                    check("sb_len", 32'(code_len), 32'(e.len));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        rst         = 1'b1;
        tecla_value = 4'h0;
        tecla_valid = 1'b0;
        code_ready  = 1'b0;
        repeat (3) tick();
        check("rst_data", 32'(code_data), 32'h0);
        check("rst_len", 32'(code_len), 32'h0);
        check("rst_valid", 32'(code_valid), 32'h0);
        check("rst_active", 32'(entry_active), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_to", 32'(timeout), 32'h0);
        rst = 1'b0;
        tick();

        // 1,2,3,# with delayed ready; keys in DONE and in the handshake cycle are dropped.
        press(4'h1);
        check("t1_active", 32'(entry_active), 32'h1);
        check("t1_len1", 32'(code_len), 32'h1);
        press(4'h2);
        press(4'h3);
        exp_q.push_back('{data: 16'h0123, len: 4'd3});
        press(4'hF);
        check("t1_valid", 32'(code_valid), 32'h1);
        check("t1_data", 32'(code_data), 32'h0123);
        check("t1_len", 32'(code_len), 32'h3);
        press(4'hE);
        check("t1_clr_drop", 32'(code_data), 32'h0123);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t1_valid_hold", 32'(code_valid), 32'h1);
        end
        code_ready  = 1'b1;
        tecla_value = 4'h8;
        tecla_valid = 1'b1;
        tick();
        code_ready  = 1'b0;
        tecla_valid = 1'b0;
        check("t1_valid_drop", 32'(code_valid), 32'h0);
        check("t1_len_after", 32'(code_len), 32'h0);
        check("t1_data_after", 32'(code_data), 32'h0);
        tick();
        check("t1_hs_key_drop", 32'(entry_active), 32'h0);

        // Overflow on the fifth digit.
        base = ovf_cnt;
        press(4'h9);
        press(4'h8);
        press(4'h7);
        press(4'h6);
        check("t2_no_ovf", 32'(ovf_cnt - base), 32'h0);
        press(4'h5);
        check("t2_ovf_once", 32'(ovf_cnt - base), 32'h1);
        check("t2_data", 32'(code_data), 32'h9876);
        check("t2_len", 32'(code_len), 32'h4);
        press(4'hC);
        check("t2_ignored", 32'(code_data), 32'h9876);
        press(4'hE);
        check("t2_clear_len", 32'(code_len), 32'h0);
        check("t2_clear_idle", 32'(entry_active), 32'h0);

        // Backspace to one digit, then to empty.
        press(4'h4);
        press(4'h5);
        press(4'hA);
        check("t3_data", 32'(code_data), 32'h0004);
        check("t3_len", 32'(code_len), 32'h1);
        press(4'hA);
        check("t3_idle", 32'(entry_active), 32'h0);
        check("t3_len0", 32'(code_len), 32'h0);

        // Held key gives exactly one digit.
        tecla_value = 4'h7;
        tecla_valid = 1'b1;
        repeat (200) tick();
        tecla_valid = 1'b0;
        tick();
        check("t4_len", 32'(code_len), 32'h1);
        check("t4_data", 32'(code_data), 32'h0007);
        press(4'hE);
        press(4'hF);
        press(4'hE);
        press(4'hA);
        check("t4_idle_len", 32'(code_len), 32'h0);
        check("t4_idle_valid", 32'(code_valid), 32'h0);
        check("t4_idle_active", 32'(entry_active), 32'h0);

`ifdef ENTRADA_TIMEOUT_EN
        base = to_cnt;
        press(4'h3);
        for (int i = 0; i < 100 && to_cnt == base; i++) tick();
        check("t5_to_seen", 32'(to_cnt - base), 32'h1);
        check("t5_to_delay", 32'(to_cyc - ev_cyc), 32'(TIMEOUT_CYCLES));
        check("t5_to_len", 32'(code_len), 32'h0);
        check("t5_to_idle", 32'(entry_active), 32'h0);
        base = to_cnt;
        press(4'h3);
        repeat (TIMEOUT_CYCLES - 2) tick();
        tecla_value = 4'h5;
        tecla_valid = 1'b1;
        tick();
        tecla_valid = 1'b0;
        tick();
        check("t5_exp_no_to", 32'(to_cnt - base), 32'h0);
        check("t5_exp_data", 32'(code_data), 32'h0035);
        check("t5_exp_len", 32'(code_len), 32'h2);
        press(4'hE);
`else
        base = to_cnt;
        press(4'h3);
        repeat (3 * TIMEOUT_CYCLES) tick();
        check("t5_no_to", 32'(to_cnt - base), 32'h0);
        check("t5_still_entry", 32'(entry_active), 32'h1);
        check("t5_len", 32'(code_len), 32'h1);
        press(4'hE);
`endif

        // Asynchronous reset in DONE discards the code.
        press(4'h1);
        press(4'hF);
        check("t6_done", 32'(code_valid), 32'h1);
        #3 rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(code_valid), 32'h0);
        check("t6_rst_data", 32'(code_data), 32'h0);
        check("t6_rst_len", 32'(code_len), 32'h0);
        check("t6_rst_active", 32'(entry_active), 32'h0);
        tecla_value = 4'h9;
        tecla_valid = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("t6_held_no_event", 32'(code_len), 32'h0);
        tecla_valid = 1'b0;
        tick();
        press(4'h6);
        exp_q.push_back('{data: 16'h0006, len: 4'd1});
        press(4'hF);
        code_ready = 1'b1;
        tick();
        code_ready = 1'b0;
        check("t6_after_len", 32'(code_len), 32'h0);
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/entrada_de_codigo.md
# entrada_de_codigo

Key-entry controller sitting downstream of `decodificador_de_teclado`. It consumes `tecla_value`/`tecla_valid` key events, assembles up to `MAX_DIGITS` decimal digits into a packed BCD buffer, and handles backspace, clear and enter keys. On enter it presents the completed code to the consumer through a valid/ready handshake.

## Interface
- `MAX_DIGITS`, default 4: buffer depth in digits, legal range 1..8.
- `TIMEOUT_CYCLES`, default 5000: inactivity limit in ENTRY, in clock cycles; must be ≥ 2.
- `clk` in, 1: single clock; all logic on rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `tecla_value` in, 4: key code from the decoder.
- `tecla_valid` in, 1: decoder valid; level or pulse, only its rising edge counts.
- `code_data` out, 4*MAX_DIGITS: packed BCD, newest digit in bits [3:0], unused nibbles 0.
- `code_len` out, 4: number of digits held, 0..MAX_DIGITS.
- `code_valid` out, 1: completed code available.
- `code_ready` in, 1: consumer accepts the code.
- `entry_active` out, 1: high in ENTRY.
- `overflow` out, 1: one-cycle pulse when a digit is rejected because the buffer is full.
- `timeout` out, 1: one-cycle pulse on inactivity clear.

## Operation
- Key codes:
  - 0x0–0x9 are digits.
  - 0xA is backspace.
  - 0xB–0xD are ignored.
  - 0xE (`*`) is clear.
  - 0xF (`#`) is enter.
- Key event: a cycle where `tecla_valid`=1 and its registered copy is 0. `tecla_value` is sampled in that cycle. Holding the key produces no repeat.
- State machine: IDLE, ENTRY, DONE. Reset state is IDLE.
- IDLE:
  - Digit: store it, len=1, go to ENTRY.
  - Backspace, clear, enter or ignored codes: no effect.
- ENTRY:
  - Digit with len<MAX_DIGITS: buffer shifts left by one nibble, digit enters [3:0], len+1.
  - Digit with len==MAX_DIGITS: buffer unchanged, `overflow` pulses.
  - Backspace: shift right by one nibble, zero-fill the top, len-1. If len reaches 0, go to IDLE.
  - Clear: buffer=0, len=0, go to IDLE.
  - Enter: go to DONE. Enter is never accepted with len=0, because ENTRY always has len≥1.
- DONE:
  - `code_valid`=1; `code_data` and `code_len` held stable.
  - All key events are dropped, including clear.
  - When `code_valid`&&`code_ready`: buffer=0, len=0, go to IDLE.
- `code_ready` outside DONE is ignored.

## Timing
- Reset values: `code_data`=0, `code_len`=0, `code_valid`=0, `entry_active`=0, `overflow`=0, `timeout`=0. Edge register=0, state=IDLE, timeout counter=0.
- Reset is asynchronous and may assert mid-entry or in DONE; a pending code is discarded with no handshake.
- Latency: every key event updates the state registers and outputs at the same rising edge at which the event is sampled. Outputs are visible in the following cycle.
- `tecla_valid` already high when reset deasserts: the edge register loads 1 on the first clock, so no spurious event is produced.
- Handshake: `code_valid` rises on the edge that samples enter. It stays high until the edge where `code_ready`=1, and is low from the next cycle. `code_ready` may be permanently high, giving exactly one DONE cycle.
- Key event in the same cycle as the DONE handshake: dropped.
- Timeout counter:
  - Clears on every accepted key event and on every state change.
  - Increments each cycle in ENTRY.
  - When it reaches TIMEOUT_CYCLES-1: buffer cleared, state goes to IDLE, and `timeout` pulses on that same edge.
  - Not active in IDLE or DONE.
  - A key event in the expiry cycle wins: the event is processed and the counter clears.
- `overflow` and `timeout` are registered single-cycle pulses and are never asserted together.

## Configuration
- `ENTRADA_TIMEOUT_EN` defined: timeout counter and `timeout` pulse present as specified.
- `ENTRADA_TIMEOUT_EN` undefined:
  - No counter logic; `timeout` is tied to 0.
  - ENTRY is left only by enter, clear, backspace-to-empty or reset.
  - `TIMEOUT_CYCLES` is unused.

## Structure
- Package `entrada_pkg`:
  - Key-code constants `KEY_BACKSPACE`=4'hA, `KEY_CLEAR`=4'hE, `KEY_ENTER`=4'hF.
  - State enum `entrada_state_t` {IDLE, ENTRY, DONE}.
- Sub-module `detector_de_borda`: rising-edge detector on `tecla_valid` (register plus AND-NOT), reset with `rst`.
- Buffer shift, length, state machine and timeout logic stay in the top module.

## Test plan
- Key events 1,2,3, then `#`, with `code_ready`=0 for 10 cycles, then 1:
  - `code_data`=16'h0123, `code_len`=3.
  - `code_valid` stays high for 10+1 cycles, then drops.
  - `code_len`=0 in the cycle after the handshake.
- Key events 9,8,7,6,5 with MAX_DIGITS=4:
  - `overflow` pulses once on the fifth key.
  - `code_data`=16'h9876.
- Key events 4,5,backspace:
  - `code_data`=16'h0004, `code_len`=1.
  - A second backspace gives state IDLE and `entry_active`=0.
- `tecla_valid` held high for 200 cycles with `tecla_value`=7:
  - Exactly one digit stored.
  - Key events `*` or `#` in IDLE cause no output change.
- Timeout build, TIMEOUT_CYCLES=50:
  - Digit 3, then idle: `timeout` pulses 50 cycles after the event, `code_len`=0.
  - A key event exactly at expiry is stored instead.
- Key events 1,`#`, then `rst` pulse mid-DONE with no handshake:
  - All outputs return to reset values asynchronously.
  - Key events after release behave normally.
